// File: rtl/led_pkg.sv
// Shared types for the multi-channel LED driver: channel modes and the
// direction state of the breathe triangle generator.
package led_pkg;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_BREATHE = 2'd3
    } led_mode_t;

    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } tri_dir_t;

endpackage

// File: rtl/led_timebase.sv
// Shared timing for all LED channels: prescaler, PWM counter, frame strobe,
// blink phase and the breathe triangle level.
module led_timebase
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned BLINK_FRAMES = 48
) (
    input  logic                clk_i,
    input  logic                rst_i,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                frame_tick_o,
    output logic                phase_o,
    output logic [PWM_BITS-1:0] tri_lvl_o
);

    localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned FcW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PsW-1:0]      PsLast = PsW'(PRESCALE - 1);
    localparam logic [PsW-1:0]      PsOne  = PsW'(1);
    localparam logic [FcW-1:0]      FcLast = FcW'(BLINK_FRAMES - 1);
    localparam logic [FcW-1:0]      FcOne  = FcW'(1);
    localparam logic [PWM_BITS-1:0] PwmMax = '1;
    localparam logic [PWM_BITS-1:0] PwmOne = PWM_BITS'(1);

    logic [PsW-1:0]      presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic [FcW-1:0]      fcnt_q, fcnt_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] tri_q, tri_d;
    tri_dir_t            dir_q, dir_d;
    logic                tick;
    logic                frame_tick;

    always_comb begin
        tick       = (presc_q == PsLast);
        presc_d    = tick ? '0 : presc_q + PsOne;
        pwm_d      = tick ? pwm_q + PwmOne : pwm_q;
        frame_tick = tick && (pwm_q == PwmMax);
    end

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (frame_tick) begin
            if (fcnt_q == FcLast) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FcOne;
            end
        end
    end

    // Direction flips on the step that lands on an endpoint, so neither end repeats.
    always_comb begin
        tri_d = tri_q;
        dir_d = dir_q;
        if (frame_tick) begin
            if (dir_q == DirUp) begin
                tri_d = tri_q + PwmOne;
                if (tri_d == PwmMax) begin
                    dir_d = DirDown;
                end
            end else begin
                tri_d = tri_q - PwmOne;
                if (tri_d == '0) begin
                    dir_d = DirUp;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            pwm_q   <= '0;
            fcnt_q  <= '0;
            phase_q <= 1'b1;
            tri_q   <= '0;
            dir_q   <= DirUp;
        end else begin
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            tri_q   <= tri_d;
            dir_q   <= dir_d;
        end
    end

    assign pwm_cnt_o    = pwm_q;
    assign frame_tick_o = frame_tick;
    assign phase_o      = phase_q;
    assign tri_lvl_o    = tri_q;

endmodule

// File: rtl/led_bank.sv
// Multi-channel LED driver with per-channel OFF/ON/BLINK/BREATHE modes.
// Configuration is double-buffered and only becomes active on a PWM frame boundary.
module led_bank
    import led_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned BLINK_FRAMES = 48,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [3:0]          cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [PWM_BITS-1:0] cfg_duty,
    output logic [CHANNELS-1:0] led,
    output logic                frame
);

    localparam logic [PWM_BITS-1:0] PwmMax = '1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                frame_tick;
    logic                phase;
    logic [PWM_BITS-1:0] tri_lvl;
    logic                cfg_hit;
    logic [CHANNELS-1:0] lit;
    logic [CHANNELS-1:0] led_q, led_d;
    logic                frame_q;

    led_timebase #(
        .PWM_BITS     (PWM_BITS),
        .PRESCALE     (PRESCALE),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timebase (
        .clk_i        (clk),
        .rst_i        (rst),
        .pwm_cnt_o    (pwm_cnt),
        .frame_tick_o (frame_tick),
        .phase_o      (phase),
        .tri_lvl_o    (tri_lvl)
    );

    assign cfg_hit = cfg_we && ({28'd0, cfg_ch} < CHANNELS);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        led_mode_t           shd_mode_q, shd_mode_d;
        led_mode_t           act_mode_q, act_mode_d;
        logic [PWM_BITS-1:0] shd_duty_q, shd_duty_d;
        logic [PWM_BITS-1:0] act_duty_q, act_duty_d;
        logic [PWM_BITS-1:0] level;

        // A write landing on frame_tick goes to the shadow only; the old shadow
        // is what loads, so the new value waits one more frame.
        always_comb begin
            shd_mode_d = shd_mode_q;
            shd_duty_d = shd_duty_q;
            act_mode_d = act_mode_q;
            act_duty_d = act_duty_q;
            if (cfg_hit && (cfg_ch == 4'(i))) begin
                shd_mode_d = led_mode_t'(cfg_mode);
                shd_duty_d = cfg_duty;
            end
            if (frame_tick) begin
                act_mode_d = shd_mode_q;
                act_duty_d = shd_duty_q;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shd_mode_q <= LED_OFF;
                shd_duty_q <= '0;
                act_mode_q <= LED_OFF;
                act_duty_q <= '0;
            end else begin
                shd_mode_q <= shd_mode_d;
                shd_duty_q <= shd_duty_d;
                act_mode_q <= act_mode_d;
                act_duty_q <= act_duty_d;
            end
        end

        always_comb begin
            level = '0;
            unique case (act_mode_q)
                LED_OFF:     level = '0;
                LED_ON:      level = act_duty_q;
                LED_BLINK:   level = phase ? act_duty_q : '0;
                LED_BREATHE: level = (tri_lvl < act_duty_q) ? tri_lvl : act_duty_q;
                default:     level = '0;
            endcase
        end

        // Full-scale level is steady on rather than lit for all but one count.
        assign lit[i] = (pwm_cnt < level) || (level == PwmMax);
    end

    assign led_d = lit ^ {CHANNELS{ACTIVE_LOW}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= {CHANNELS{ACTIVE_LOW}};
            frame_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            frame_q <= frame_tick;
        end
    end

    assign led   = led_q;
    assign frame = frame_q;

endmodule
